// File: rtl/mode7_scan.sv
// mode7_scan: VGA pixel-rate scan generator for the Mode 7 renderer.
// Produces registered x/y, syncs, blanking, frame strobe and frame angle.
module mode7_scan #(
    parameter int DIV        = 4,
    parameter int H_DISPLAY  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_DISPLAY  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int ANGLE_INIT = 0,
    parameter int ANGLE_STEP = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rot_cw,
    input  logic        rot_ccw,
    output logic        pixel_tick,
    output logic [15:0] x,
    output logic [15:0] y,
    output logic        hsync,
    output logic        vsync,
    output logic        video_on,
    output logic        frame_start,
    output logic [9:0]  angle
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DW      = $clog2(DIV);

    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [15:0]   H_LAST   = 16'(H_TOTAL - 1);
    localparam logic [15:0]   V_LAST   = 16'(V_TOTAL - 1);
    localparam logic [15:0]   H_VIS    = 16'(H_DISPLAY);
    localparam logic [15:0]   V_VIS    = 16'(V_DISPLAY);
    localparam logic [15:0]   HS_LO    = 16'(H_DISPLAY + H_FRONT);
    localparam logic [15:0]   HS_HI    = 16'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [15:0]   VS_LO    = 16'(V_DISPLAY + V_FRONT);
    localparam logic [15:0]   VS_HI    = 16'(V_DISPLAY + V_FRONT + V_SYNC);

    localparam logic [9:0]         A_INIT = 10'(ANGLE_INIT);
    localparam logic signed [10:0] A_STEP = 11'(ANGLE_STEP);
    localparam logic signed [10:0] A_FULL = 11'sd360;

    logic [DW-1:0] div_q, div_d;
    logic          tick_q, tick_d;
    logic [15:0]   x_q, x_d;
    logic [15:0]   y_q, y_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          von_q, von_d;
    logic          fs_q, fs_d;
    logic [9:0]    angle_q, angle_d;

    logic               div_wrap;
    logic signed [10:0] a_up;
    logic signed [10:0] a_dn;

    // Next-state for divider and raster counters, outputs decoded from them
    always_comb begin
        div_wrap = (div_q == DIV_LAST);
        div_d    = div_wrap ? '0 : div_q + 1'b1;
        tick_d   = div_wrap;
        x_d      = x_q;
        y_d      = y_q;
        fs_d     = 1'b0;
        if (div_wrap) begin
            if (x_q == H_LAST) begin
                x_d = '0;
                if (y_q == V_LAST) begin
                    y_d  = '0;
                    fs_d = 1'b1;
                end else begin
                    y_d = y_q + 16'd1;
                end
            end else begin
                x_d = x_q + 16'd1;
            end
        end
        hsync_d = !((x_d >= HS_LO) && (x_d < HS_HI));
        vsync_d = !((y_d >= VS_LO) && (y_d < VS_HI));
        von_d   = (x_d < H_VIS) && (y_d < V_VIS);
    end

    // Angle steps once per frame, only in the frame_start clock
    always_comb begin
        a_up    = $signed({1'b0, angle_q}) + A_STEP;
        a_dn    = $signed({1'b0, angle_q}) - A_STEP;
        angle_d = angle_q;
        if (fs_q && (rot_cw ^ rot_ccw)) begin
            if (rot_cw) begin
                angle_d = (a_up >= A_FULL) ? 10'(a_up - A_FULL) : 10'(a_up);
            end else begin
                angle_d = a_dn[10] ? 10'(a_dn + A_FULL) : 10'(a_dn);
            end
        end
    end

    // State registers; reset lands on pixel (0,0) of an unstarted frame
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q   <= '0;
            tick_q  <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            von_q   <= 1'b1;
            fs_q    <= 1'b0;
            angle_q <= A_INIT;
        end else begin
            div_q   <= div_d;
            tick_q  <= tick_d;
            x_q     <= x_d;
            y_q     <= y_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            von_q   <= von_d;
            fs_q    <= fs_d;
            angle_q <= angle_d;
        end
    end

    assign pixel_tick  = tick_q;
    assign x           = x_q;
    assign y           = y_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = von_q;
    assign frame_start = fs_q;
    assign angle       = angle_q;

endmodule

// File: tb/tb_mode7_scan.sv
// tb_mode7_scan: closed-form raster/angle model checked every cycle,
// plus literal expectations, across three parameterisations.
module tb_mode7_scan;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [2:0] rcw, rccw;
    logic [2:0] pt, hs, vs, von, fs;
    logic [2:0][15:0] xs, ys;
    logic [2:0][9:0] ang;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mode7_scan u0 (
        .clk(clk), .reset(reset), .rot_cw(rcw[0]), .rot_ccw(rccw[0]),
        .pixel_tick(pt[0]), .x(xs[0]), .y(ys[0]), .hsync(hs[0]),
        .vsync(vs[0]), .video_on(von[0]), .frame_start(fs[0]),
        .angle(ang[0])
    );

    mode7_scan #(
        .DIV(2), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(2),
        .ANGLE_INIT(358), .ANGLE_STEP(1)
    ) u1 (
        .clk(clk), .reset(reset), .rot_cw(rcw[1]), .rot_ccw(rccw[1]),
        .pixel_tick(pt[1]), .x(xs[1]), .y(ys[1]), .hsync(hs[1]),
        .vsync(vs[1]), .video_on(von[1]), .frame_start(fs[1]),
        .angle(ang[1])
    );

    mode7_scan #(
        .DIV(3), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(2),
        .ANGLE_INIT(355), .ANGLE_STEP(7)
    ) u2 (
        .clk(clk), .reset(reset), .rot_cw(rcw[2]), .rot_ccw(rccw[2]),
        .pixel_tick(pt[2]), .x(xs[2]), .y(ys[2]), .hsync(hs[2]),
        .vsync(vs[2]), .video_on(von[2]), .frame_start(fs[2]),
        .angle(ang[2])
    );

    typedef struct {
        logic pt;
        int   x;
        int   y;
        logic hs;
        logic vs;
        logic von;
        logic fs;
    } exp_t;

    // Closed-form expectation after kk clocks since reset release
    function automatic exp_t model(input int i, input int kk);
        exp_t e;
        int dv, hd, hf, hsn, hb, vd, vf, vsn, vb, ht, vt, t;
        if (i == 0) begin
            dv = 4; hd = 640; hf = 16; hsn = 96; hb = 48;
            vd = 480; vf = 10; vsn = 2; vb = 33;
        end else begin
            dv = (i == 1) ? 2 : 3;
            hd = 8; hf = 2; hsn = 2; hb = 2;
            vd = 4; vf = 1; vsn = 1; vb = 2;
        end
        ht = hd + hf + hsn + hb;
        vt = vd + vf + vsn + vb;
        t = kk / dv;
        e.pt = (kk > 0) && (kk % dv == 0);
        e.x = t % ht;
        e.y = (t / ht) % vt;
        e.hs = !((e.x >= hd + hf) && (e.x < hd + hf + hsn));
        e.vs = !((e.y >= vd + vf) && (e.y < vd + vf + vsn));
        e.von = (e.x < hd) && (e.y < vd);
        e.fs = e.pt && (e.x == 0) && (e.y == 0);
        return e;
    endfunction

    function automatic int a_init(input int i);
        return (i == 0) ? 0 : (i == 1) ? 358 : 355;
    endfunction

    function automatic int a_step(input int i);
        return (i == 2) ? 7 : 1;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    int k;
    int ang_m [3];

    // Model state: clocks since release and per-instance angle
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            k <= 0;
            for (int i = 0; i < 3; i++) ang_m[i] <= a_init(i);
        end else begin
            for (int i = 0; i < 3; i++) begin
                exp_t m;
                int a;
                m = model(i, k);
                a = ang_m[i];
                if (m.fs && (rcw[i] ^ rccw[i])) begin
                    if (rcw[i]) begin
                        a = a + a_step(i);
                        if (a >= 360) a = a - 360;
                    end else begin
                        a = a - a_step(i);
                        if (a < 0) a = a + 360;
                    end
                end
                ang_m[i] <= a;
            end
            k <= k + 1;
        end
    end

    exp_t ce;

    // Compare every DUT output against the model each cycle
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            ce = model(i, k);
            chk($sformatf("u%0d.pixel_tick", i), int'(pt[i]), int'(ce.pt));
            chk($sformatf("u%0d.x", i), int'(xs[i]), ce.x);
            chk($sformatf("u%0d.y", i), int'(ys[i]), ce.y);
            chk($sformatf("u%0d.hsync", i), int'(hs[i]), int'(ce.hs));
            chk($sformatf("u%0d.vsync", i), int'(vs[i]), int'(ce.vs));
            chk($sformatf("u%0d.video_on", i), int'(von[i]), int'(ce.von));
            chk($sformatf("u%0d.frame_start", i), int'(fs[i]), int'(ce.fs));
            chk($sformatf("u%0d.angle", i), int'(ang[i]), ang_m[i]);
        end
    end

    task automatic drive_rot(input int n);
        rcw[0]  = 1'b0;
        rccw[0] = 1'b0;
        rcw[1]  = (n < 500) || (n >= 950 && n < 1150) ||
                  (n >= 1200 && n < 1300);
        rccw[1] = (n >= 500 && n < 1150);
        rcw[2]  = (n < 700) || (n >= 1100 && n < 1200);
        rccw[2] = (n >= 400 && n < 700);
    endtask

    int hcnt, vcnt, vocnt;

    initial begin
        hcnt = 0;
        vcnt = 0;
        vocnt = 0;
        drive_rot(0);
        repeat (3) @(negedge clk);
        chk("rst.x", int'(xs[0]), 0);
        chk("rst.hsync", int'(hs[0]), 1);
        chk("rst.video_on", int'(von[0]), 1);
        chk("rst.angle1", int'(ang[1]), 358);
        chk("rst.angle2", int'(ang[2]), 355);
        reset = 1'b0;
        for (int n = 1; n <= 3300; n++) begin
            @(negedge clk);
            if (n <= 3200 && !hs[0]) hcnt++;
            if (n <= 224 && !vs[1]) vcnt++;
            if (n <= 224 && von[1]) vocnt++;
            if (n == 3) chk("u0.tick_k3", int'(pt[0]), 0);
            if (n == 4) begin
                chk("u0.tick_k4", int'(pt[0]), 1);
                chk("u0.x_k4", int'(xs[0]), 1);
            end
            if (n == 3200) begin
                chk("u0.x_wrap", int'(xs[0]), 0);
                chk("u0.y_wrap", int'(ys[0]), 1);
                chk("u0.hsync_low_clks", hcnt, 384);
            end
            if (n == 223) chk("u1.fs_k223", int'(fs[1]), 0);
            if (n == 224) begin
                chk("u1.fs_k224", int'(fs[1]), 1);
                chk("u1.vsync_low_clks", vcnt, 28);
                chk("u1.video_on_clks", vocnt, 64);
            end
            if (n == 225)  chk("u1.cw_359", int'(ang[1]), 359);
            if (n == 449)  chk("u1.cw_0", int'(ang[1]), 0);
            if (n == 673)  chk("u1.ccw_359", int'(ang[1]), 359);
            if (n == 897)  chk("u1.ccw_358", int'(ang[1]), 358);
            if (n == 1121) chk("u1.both_hold", int'(ang[1]), 358);
            if (n == 1345) chk("u1.mid_hold", int'(ang[1]), 358);
            if (n == 337)  chk("u2.step7_2", int'(ang[2]), 2);
            if (n == 673)  chk("u2.both_hold", int'(ang[2]), 2);
            if (n == 1009) chk("u2.none_hold", int'(ang[2]), 2);
            if (n == 1345) chk("u2.mid_hold", int'(ang[2]), 2);
            drive_rot(n);
        end
        chk("u0.x_pre_rst", int'(xs[0]), 25);
        #2 reset = 1'b1;
        #1;
        chk("mrst.x", int'(xs[0]), 0);
        chk("mrst.y", int'(ys[0]), 0);
        chk("mrst.tick", int'(pt[0]), 0);
        chk("mrst.hsync", int'(hs[0]), 1);
        chk("mrst.vsync", int'(vs[0]), 1);
        chk("mrst.angle2", int'(ang[2]), 355);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rel.tick_k3", int'(pt[0]), 0);
        @(negedge clk);
        chk("rel.tick_k4", int'(pt[0]), 1);
        chk("rel.x_k4", int'(xs[0]), 1);
        repeat (20) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mode7_scan.md
# mode7_scan

Upstream scan generator for the Mode 7 renderer. Divides the system clock into a 640x480@60 VGA pixel rate and generates registered pixel coordinates, sync, blanking and frame-start strobes. Also holds the per-frame rotation angle (0..359 degrees) that indexes the transform stage's sine/cosine tables. The transform stage consumes x, y and angle directly; the video DAC consumes hsync, vsync and video_on.

## Interface
- DIV, 4: system clocks per pixel (minimum 2)
- H_DISPLAY, 640 / H_FRONT, 16 / H_SYNC, 96 / H_BACK, 48: horizontal timing in pixels
- V_DISPLAY, 480 / V_FRONT, 10 / V_SYNC, 2 / V_BACK, 33: vertical timing in lines
- ANGLE_INIT, 0: angle after reset (0..359)
- ANGLE_STEP, 1: degrees per frame while rotating (1..359)

Ports:
- clk  in  1  system clock; one clock domain, rising edge
- reset  in  1  asynchronous, active-high
- rot_cw  in  1  level; rotate clockwise (angle increases)
- rot_ccw  in  1  level; rotate counter-clockwise (angle decreases)
- pixel_tick  out  1  one-clk strobe, once every DIV clks
- x  out  16  horizontal counter, zero-extended (0..799)
- y  out  16  vertical counter, zero-extended (0..524)
- hsync  out  1  active low
- vsync  out  1  active low
- video_on  out  1  high when x < H_DISPLAY and y < V_DISPLAY
- frame_start  out  1  one-clk strobe when the counters wrap to (0,0)
- angle  out  10  current rotation angle, 0..359

## Operation
- Divider: div counts 0..DIV-1 and wraps. pixel_tick is registered and is high in the clk after div == DIV-1.
- H counter: advances on each pixel_tick. H_TOTAL = sum of the H parameters (800); it wraps from H_TOTAL-1 to 0.
- V counter: advances when H wraps. V_TOTAL = 525; it wraps from V_TOTAL-1 to 0.
- All outputs are registered and decoded from the next counter values, so hsync, vsync and video_on always describe the current x, y:
  - hsync = 0 when H_DISPLAY+H_FRONT <= x < H_DISPLAY+H_FRONT+H_SYNC (656..751).
  - vsync = 0 when 490 <= y <= 491.
  - video_on as defined in the port list.
- frame_start is high for exactly the clk in which (x, y) first read (0,0) after (799,524). It is not asserted after reset.
- Angle update happens only in the frame_start clk, using rot_cw and rot_ccw sampled in that clk:
  - cw only: a = angle + ANGLE_STEP; if a >= 360 then a -= 360.
  - ccw only: a = angle - ANGLE_STEP; if the result underflows, add 360. Compute in 11-bit signed.
  - both or neither: angle is unchanged.
- Angle never leaves 0..359 and never changes mid-frame.
- No handshake: consumers sample x, y and video_on on pixel_tick or on any clk. Values are stable for DIV clks.

## Timing
- Reset values (asynchronous, immediate):
  - div = 0, x = 0, y = 0, angle = ANGLE_INIT.
  - pixel_tick = 0, frame_start = 0.
  - hsync = 1, vsync = 1, video_on = 1 (consistent with (0,0)).
- First pixel_tick is in the DIV-th clk after reset deassertion. x becomes 1 in that same clk.
- Period: 1 line = 800 ticks = 800·DIV clks. 1 frame = 420000 ticks.
- Sync, blanking and coordinates change together in the pixel_tick clk, with zero relative skew.
- Reset mid-frame returns all state to reset values immediately. The angle is restored to ANGLE_INIT, not preserved.
- rot_cw and rot_ccw are assumed synchronous to clk. Glitches outside the frame_start clk have no effect.

## Test plan
- Reset then run 3200 clks (DIV=4): pixel_tick every 4th clk; x counts 0..799 and wraps; y increments once, 0 -> 1; hsync low exactly for x = 656..751 (96 ticks).
- Run one full frame: vsync low for y = 490..491 (1600 ticks); video_on high for 307200 ticks per frame; frame_start pulses once, 1,680,000 clks after the previous one.
- rot_cw held, ANGLE_INIT=358, STEP=1: angle goes 359 then 0 on successive frame_starts. rot_ccw held from 0: angle goes 359 then 358.
- STEP=7, ANGLE_INIT=355, rot_cw: next angle is 2. Both inputs high: angle holds. rot_cw toggled only mid-frame: angle holds.
- Assert reset at x=400, y=300 with angle=123: in the same clk x=0, y=0, angle=ANGLE_INIT, hsync=vsync=1, pixel_tick=0. The next tick follows DIV clks after release.
